apb_cdc_arbiter: RTL and testbench

- Round-robin arbiter and APB master sequencer that shares the source-side slave port of the apb_cdc bridge between NUM_REQ local requesters.
- Each requester posts a simple valid/done transaction. The arbiter grants one requester at a time and drives a compliant APB SETUP/ACCESS sequence into the bridge.
- Completion returns PRDATA/PSLVERR to the granted requester.
- A per-transfer timeout reports an error to the requester if the far clock domain stalls, without violating APB.

---
 rtl/apb_cdc_arbiter.sv | 177 +++++++++++++++++
 tb/tb_apb_cdc_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cdc_arbiter.sv
// Round-robin arbiter that shares one APB master port (the apb_cdc source side)
// between NUM_REQ local requesters, with a per-transfer ACCESS-phase timeout.
module apb_cdc_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  src_clk,
    input  logic                  src_rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [DW-1:0]         req_rdata,
    output logic                  req_err,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic [AW-1:0]         m_PADDR,
    output logic [DW-1:0]         m_PWDATA,
    output logic                  m_PWRITE,
    output logic                  m_PSEL,
    output logic                  m_PENABLE,
    input  logic [DW-1:0]         m_PRDATA,
    input  logic                  m_PREADY,
    input  logic                  m_PSLVERR
);

    localparam int CW = 16;

    // Handshake: a requester raises req_valid and holds it (with its fields)
    // until it sees its req_done bit; req_done is a single-cycle pulse and
    // req_rdata/req_err are valid with it and hold until the next completion.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_ORPHAN = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [2:0]         last, last_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               any_valid;
    logic [2:0]         pick;
    logic               timeout_hit;

    logic [AW-1:0]      paddr_nx;
    logic [DW-1:0]      pwdata_nx;
    logic               pwrite_nx;
    logic               psel_nx;
    logic               penable_nx;
    logic [NUM_REQ-1:0] done_nx;
    logic [DW-1:0]      rdata_nx;
    logic               err_nx;
    logic [2:0]         grant_nx;
    logic               busy_nx;

    // Search last+1, last+2, ... with wrap; smallest distance wins.
    always_comb begin
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        pick      = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = idx[2:0];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    // State register plus the registered outputs.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state     <= S_IDLE;
            last      <= 3'(NUM_REQ - 1);
            cnt       <= '0;
            m_PADDR   <= '0;
            m_PWDATA  <= '0;
            m_PWRITE  <= 1'b0;
            m_PSEL    <= 1'b0;
            m_PENABLE <= 1'b0;
            req_done  <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            cnt       <= cnt_nx;
            m_PADDR   <= paddr_nx;
            m_PWDATA  <= pwdata_nx;
            m_PWRITE  <= pwrite_nx;
            m_PSEL    <= psel_nx;
            m_PENABLE <= penable_nx;
            req_done  <= done_nx;
            req_rdata <= rdata_nx;
            req_err   <= err_nx;
            grant_id  <= grant_nx;
            busy      <= busy_nx;
        end
    end

    // Next-state logic. PREADY has priority over the timeout in ACCESS.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (any_valid) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_ACCESS;
            S_ACCESS: begin
                if (m_PREADY)         state_nx = S_DONE;
                else if (timeout_hit) state_nx = S_ORPHAN;
            end
            S_DONE:   state_nx = S_IDLE;
            S_ORPHAN: if (m_PREADY) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output logic: values for the next cycle, derived from the transition.
    always_comb begin
        paddr_nx   = m_PADDR;
        pwdata_nx  = m_PWDATA;
        pwrite_nx  = m_PWRITE;
        grant_nx   = grant_id;
        last_nx    = last;
        rdata_nx   = req_rdata;
        err_nx     = req_err;
        cnt_nx     = '0;
        done_nx    = '0;
        psel_nx    = (state_nx == S_SETUP) || (state_nx == S_ACCESS) ||
                     (state_nx == S_ORPHAN);
        penable_nx = (state_nx == S_ACCESS) || (state_nx == S_ORPHAN);
        busy_nx    = (state_nx != S_IDLE);
        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    paddr_nx  = req_addr[int'(pick)*AW +: AW];
                    pwdata_nx = req_wdata[int'(pick)*DW +: DW];
                    pwrite_nx = req_write[pick];
                    grant_nx  = pick;
                    last_nx   = pick;
                end
            end
            S_ACCESS: begin
                if (m_PREADY) begin
                    rdata_nx = m_PWRITE ? '0 : m_PRDATA;
                    err_nx   = m_PSLVERR;
                    done_nx  = NUM_REQ'(1) << grant_id;
                end else if (timeout_hit) begin
                    // The bus stays in ACCESS until PREADY; only the requester is released.
                    rdata_nx = '0;
                    err_nx   = 1'b1;
                    done_nx  = NUM_REQ'(1) << grant_id;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    a_penable_needs_psel: assert property (@(posedge src_clk) disable iff (src_rst)
        m_PENABLE |-> m_PSEL);
    a_done_onehot: assert property (@(posedge src_clk) disable iff (src_rst)
        $onehot0(req_done));

endmodule

// File: tb/tb_apb_cdc_arbiter.sv
// Directed bench for apb_cdc_arbiter: table of single transfers plus
// hand-written fairness, timeout/orphan and mid-transfer reset sequences.
module tb_apb_cdc_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic                  src_clk;
    logic                  src_rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_done;
    logic [DW-1:0]         req_rdata;
    logic                  req_err;
    logic [2:0]            grant_id;
    logic                  busy;
    logic [AW-1:0]         m_PADDR;
    logic [DW-1:0]         m_PWDATA;
    logic                  m_PWRITE;
    logic                  m_PSEL;
    logic                  m_PENABLE;
    logic [DW-1:0]         m_PRDATA;
    logic                  m_PREADY;
    logic                  m_PSLVERR;

    apb_cdc_arbiter #(
        .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .src_clk(src_clk), .src_rst(src_rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
        .grant_id(grant_id), .busy(busy),
        .m_PADDR(m_PADDR), .m_PWDATA(m_PWDATA), .m_PWRITE(m_PWRITE),
        .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE),
        .m_PRDATA(m_PRDATA), .m_PREADY(m_PREADY), .m_PSLVERR(m_PSLVERR)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          ready_at;   // ACCESS cycle (1-based) in which PREADY is high
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    // One transfer from one requester; slave answers on ACCESS cycle ready_at.
    task automatic run_txn(input vec_t v);
        int acc;
        bit setup_seen;
        bit done_seen;
        acc = 0; setup_seen = 0; done_seen = 0;
        req_addr[v.id*AW +: AW]  = v.addr;
        req_wdata[v.id*DW +: DW] = v.wdata;
        req_write[v.id]          = v.wr;
        req_valid[v.id]          = 1'b1;
        m_PREADY  = 1'b0;
        m_PRDATA  = v.prdata;
        m_PSLVERR = v.slverr;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge src_clk);
            if (req_done != 0) begin
                done_seen = 1;
                check("txn_done_vec", req_done, 64'(1 << v.id));
                check("txn_rdata", req_rdata, v.exp_rdata);
                check("txn_err", req_err, v.exp_err);
                check("txn_grant", grant_id, v.id);
                check("txn_psel_drop", {m_PSEL, m_PENABLE}, 2'b00);
                check("txn_latency", c, v.ready_at + 1);
                req_valid[v.id] = 1'b0;
                m_PREADY = 1'b0;
            end else if (m_PSEL && !m_PENABLE) begin
                setup_seen = 1;
            end else if (m_PSEL && m_PENABLE) begin
                acc++;
                if (acc == 1) begin
                    check("txn_setup_first", setup_seen, 1'b1);
                    check("txn_paddr", m_PADDR, v.addr);
                    check("txn_pwrite", m_PWRITE, v.wr);
                    check("txn_pwdata", m_PWDATA, v.wdata);
                end
                m_PREADY = (acc == v.ready_at);
            end
        end
        if (!done_seen) check("txn_no_done", 1'b0, 1'b1);
        @(negedge src_clk);
        check("txn_done_single", req_done, '0);
        check("txn_idle", busy, 1'b0);
    endtask

    initial begin
        int k;
        int acc;
        bit done_seen;
        vec_t post_to;

        // id, wr, addr, wdata, prdata, slverr, ready_at, exp_rdata, exp_err
        vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,         32'hA5A5_0001, 1'b0, 3, 32'hA5A5_0001, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1, 32'h0,         1'b1};
        vecs[2] = '{0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h7777_7777, 1'b0, 1, 32'h0,         1'b0};
        vecs[3] = '{1, 1'b0, 32'h0000_2000, 32'h0,         32'hCAFE_BABE, 1'b1, 2, 32'hCAFE_BABE, 1'b1};
        vecs[4] = '{1, 1'b0, 32'h0000_3000, 32'h0,         32'h55AA_55AA, 1'b1, 8, 32'h55AA_55AA, 1'b1};
        post_to = '{0, 1'b0, 32'h0000_0500, 32'h0,         32'h600D_D00D, 1'b1, 2, 32'h600D_D00D, 1'b1};

        src_rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_PRDATA = '0; m_PREADY = 1'b0; m_PSLVERR = 1'b0;
        repeat (2) @(negedge src_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_psel", {m_PSEL, m_PENABLE}, 2'b00);
        check("rst_done", req_done, '0);
        check("rst_grant", grant_id, 3'd0);
        check("rst_paddr", m_PADDR, '0);
        check("rst_err", req_err, 1'b0);
        src_rst = 1'b0;
        @(negedge src_clk);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // Fairness: both requesting, slave always ready.
        req_addr  = {32'h0000_0B00, 32'h0000_0A00};
        req_write = '0;
        m_PRDATA  = 32'h1111_0000; m_PSLVERR = 1'b0; m_PREADY = 1'b1;
        req_valid = 2'b11;
        k = 0;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge src_clk);
            if (req_done != 0) begin
                check("fair_done", req_done, 64'(1 << (k % 2)));
                check("fair_grant", grant_id, k % 2);
                k++;
                if (k == 4) req_valid = '0;
            end
        end
        check("fair_count", k, 4);
        m_PREADY = 1'b0;
        repeat (2) @(negedge src_clk);
        check("fair_idle", busy, 1'b0);

        // Timeout: slave never answers until well after the orphan done.
        req_addr[1*AW +: AW] = 32'h0000_0300;
        req_write[1] = 1'b0;
        m_PRDATA = 32'h9999_9999; m_PSLVERR = 1'b0;
        req_valid[1] = 1'b1;
        acc = 0; done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge src_clk);
            if (req_done != 0) begin
                done_seen = 1;
                check("to_done_vec", req_done, 2'b10);
                check("to_err", req_err, 1'b1);
                check("to_rdata", req_rdata, '0);
                check("to_bus_held", {m_PSEL, m_PENABLE}, 2'b11);
                check("to_access_cycles", acc, TIMEOUT);
            end else if (m_PSEL && m_PENABLE) begin
                acc++;
            end
        end
        if (!done_seen) check("to_no_done", 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge src_clk);
            check("orphan_no_done", req_done, '0);
            check("orphan_bus_held", {m_PSEL, m_PENABLE, m_PADDR}, {2'b11, 32'h0000_0300});
        end
        m_PREADY = 1'b1; m_PRDATA = 32'hFFFF_FFFF; m_PSLVERR = 1'b0;
        @(negedge src_clk);
        m_PREADY = 1'b0;
        check("orphan_release", {m_PSEL, m_PENABLE, busy}, 3'b000);
        check("orphan_no_2nd_done", req_done, '0);
        check("orphan_discard", {req_err, req_rdata}, {1'b1, 32'h0});
        @(negedge src_clk);
        check("orphan_quiet", req_done, '0);
        run_txn(post_to);

        // Reset in the middle of ACCESS; last pointer is 0 before the reset.
        req_addr[0*AW +: AW] = 32'h0000_4000;
        req_write[0] = 1'b0;
        m_PREADY = 1'b0;
        req_valid[0] = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            @(negedge src_clk);
            if (m_PSEL && m_PENABLE) done_seen = 1;
        end
        check("rst_reached_access", done_seen, 1'b1);
        #2 src_rst = 1'b1;
        #1;
        check("arst_psel", {m_PSEL, m_PENABLE, busy}, 3'b000);
        check("arst_bus", {m_PADDR, m_PWRITE}, '0);
        check("arst_resp", {req_done, req_err, req_rdata}, '0);
        check("arst_grant", grant_id, 3'd0);
        @(negedge src_clk);
        src_rst = 1'b0;
        req_addr  = {32'h0000_6000, 32'h0000_5000};
        req_valid = 2'b11;
        m_PREADY  = 1'b1; m_PRDATA = 32'h0000_5A5A; m_PSLVERR = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            @(negedge src_clk);
            if (req_done != 0) begin
                done_seen = 1;
                check("post_rst_done", req_done, 2'b01);
                check("post_rst_grant", grant_id, 3'd0);
                check("post_rst_rdata", req_rdata, 32'h0000_5A5A);
                req_valid = '0;
            end
        end
        if (!done_seen) check("post_rst_no_done", 1'b0, 1'b1);
        m_PREADY = 1'b0;
        repeat (2) @(negedge src_clk);
        check("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
